// File: rtl/flex_stp_sr_frame.sv
// Serial-to-parallel shift register that frames NUM_BITS words and hands each
// completed word to a consumer over a valid/ready handshake with sticky overrun.
module flex_stp_sr_frame #(
  parameter int   NUM_BITS       = 4,
  parameter bit   SHIFT_MSB      = 1'b1,
  parameter logic INACTIVE_VALUE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        shift_enable,
  input  logic                        serial_in,
  output logic [NUM_BITS-1:0]         parallel_out,
  output logic [$clog2(NUM_BITS)-1:0] bit_count,
  output logic [NUM_BITS-1:0]         data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        overrun
);

  localparam int CW = $clog2(NUM_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  logic [NUM_BITS-1:0] sr_shift;
  logic                complete;
  logic                accept;

  always_comb begin
    sr_shift = parallel_out;
    if (SHIFT_MSB)
      sr_shift = {parallel_out[NUM_BITS-2:0], serial_in};
    else
      sr_shift = {serial_in, parallel_out[NUM_BITS-1:1]};
  end

  assign complete = shift_enable && (bit_count == LAST_BIT);
  assign accept   = data_valid && data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      parallel_out <= {NUM_BITS{INACTIVE_VALUE}};
      bit_count    <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else if (clear) begin
      // abort drops the partial word and flags but keeps the last captured word
      parallel_out <= {NUM_BITS{INACTIVE_VALUE}};
      bit_count    <= '0;
      data_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (shift_enable) begin
        parallel_out <= sr_shift;
        bit_count    <= complete ? '0 : bit_count + 1'b1;
      end
      if (complete) begin
        // a word landing on an unaccepted one is dropped, not queued
        if (!data_valid || data_ready) begin
          data_out   <= sr_shift;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flex_stp_sr_frame.sv
// Bench for flex_stp_sr_frame: an MSB-shifting and an LSB-shifting instance,
// completed words tracked through a scoreboard queue.
module tb_flex_stp_sr_frame;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0, shift_enable = 1'b0, serial_in = 1'b1, data_ready = 1'b0;
  logic [3:0] parallel_out, data_out;
  logic [1:0] bit_count;
  logic       data_valid, overrun;
  logic       clear_l = 1'b0, shift_enable_l = 1'b0, serial_in_l = 1'b1, data_ready_l = 1'b0;
  logic [3:0] parallel_out_l, data_out_l;
  logic [1:0] bit_count_l;
  logic       data_valid_l, overrun_l;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_q_l[$];
  logic [3:0] exp_w;

  always #5 tb_clk = ~tb_clk;

  flex_stp_sr_frame #(.NUM_BITS(4), .SHIFT_MSB(1'b1), .INACTIVE_VALUE(1'b1)) dut_msb (
    .clk(tb_clk), .rst(rst), .clear(clear), .shift_enable(shift_enable),
    .serial_in(serial_in), .parallel_out(parallel_out), .bit_count(bit_count),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .overrun(overrun)
  );

  flex_stp_sr_frame #(.NUM_BITS(4), .SHIFT_MSB(1'b0), .INACTIVE_VALUE(1'b1)) dut_lsb (
    .clk(tb_clk), .rst(rst), .clear(clear_l), .shift_enable(shift_enable_l),
    .serial_in(serial_in_l), .parallel_out(parallel_out_l), .bit_count(bit_count_l),
    .data_out(data_out_l), .data_valid(data_valid_l), .data_ready(data_ready_l),
    .overrun(overrun_l)
  );

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    shift_enable = 1'b1;
    serial_in = b;
    step();
    shift_enable = 1'b0;
  endtask

  task automatic shift_bit_l(input logic b);
    shift_enable_l = 1'b1;
    serial_in_l = b;
    step();
    shift_enable_l = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++;
    if ({parallel_out, bit_count, data_out, data_valid, overrun} !== {4'b1111, 2'd0, 4'b0000, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got po=%b bc=%0d do=%b dv=%b ov=%b, expected po=1111 bc=0 do=0000 dv=0 ov=0",
               parallel_out, bit_count, data_out, data_valid, overrun);
    end
    shift_enable = 1'b1;
    serial_in = 1'b0;
    step();
    shift_enable = 1'b0;
    n_checks++;
    if ({parallel_out, bit_count, data_valid, overrun} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_hold: got po=%b bc=%0d dv=%b ov=%b, expected po=1111 bc=0 dv=0 ov=0",
               parallel_out, bit_count, data_valid, overrun);
    end
    n_checks++;
    if ({parallel_out_l, bit_count_l, data_valid_l} !== {4'b1111, 2'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_lsb: got po=%b bc=%0d dv=%b, expected po=1111 bc=0 dv=0",
               parallel_out_l, bit_count_l, data_valid_l);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    data_ready = 1'b0;
    shift_bit(1'b1);
    shift_bit(1'b1);
    shift_bit(1'b0);
    n_checks++;
    if (bit_count !== 2'd3 || data_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_partial: got bc=%0d dv=%b, expected bc=3 dv=0", bit_count, data_valid);
    end
    exp_q.push_back(4'b1101);
    shift_bit(1'b1);
    n_checks++;
    if ({parallel_out, bit_count, data_valid} !== {4'b1101, 2'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL stream_word: got po=%b bc=%0d dv=%b, expected po=1101 bc=0 dv=1",
               parallel_out, bit_count, data_valid);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL stream_sb: got empty scoreboard, expected one word");
    end else begin
      exp_w = exp_q.pop_front();
      if (data_out !== exp_w) begin
        n_errors++;
        $display("FAIL stream_data: got %b expected %b", data_out, exp_w);
      end
    end
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    shift_bit(1'b0);
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    n_checks++;
    if ({parallel_out, data_out, data_valid, overrun} !== {4'b0010, 4'b1101, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL overrun_set: got po=%b do=%b dv=%b ov=%b, expected po=0010 do=1101 dv=1 ov=1",
               parallel_out, data_out, data_valid, overrun);
    end
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    n_checks++;
    if ({data_out, data_valid, overrun} !== {4'b1101, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL overrun_accept: got do=%b dv=%b ov=%b, expected do=1101 dv=0 ov=1",
               data_out, data_valid, overrun);
    end
    data_ready = 1'b1;
    step();
    step();
    data_ready = 1'b0;
    n_checks++;
    if (overrun !== 1'b1 || data_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_sticky: got ov=%b dv=%b, expected ov=1 dv=0", overrun, data_valid);
    end
    shift_bit(1'b1);
    clear = 1'b1;
    shift_enable = 1'b1;
    serial_in = 1'b0;
    step();
    clear = 1'b0;
    shift_enable = 1'b0;
    n_checks++;
    if ({parallel_out, bit_count, data_out, data_valid, overrun} !== {4'b1111, 2'd0, 4'b1101, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL overrun_clear: got po=%b bc=%0d do=%b dv=%b ov=%b, expected po=1111 bc=0 do=1101 dv=0 ov=0",
               parallel_out, bit_count, data_out, data_valid, overrun);
    end
  endtask

  task automatic test_discontiguous();
    logic [3:0] steps [4];
    steps = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(4'b0000);
      shift_bit(1'b0);
      step();
      n_checks++;
      if (parallel_out !== steps[i] || bit_count !== 2'(i + 1) || data_valid !== (i == 3)) begin
        n_errors++;
        $display("FAIL discontig_bit%0d: got po=%b bc=%0d dv=%b, expected po=%b bc=%0d dv=%b",
                 i, parallel_out, bit_count, data_valid, steps[i], 2'(i + 1), (i == 3));
      end
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL discontig_sb: got empty scoreboard, expected one word");
    end else begin
      exp_w = exp_q.pop_front();
      if (data_out !== exp_w) begin
        n_errors++;
        $display("FAIL discontig_data: got %b expected %b", data_out, exp_w);
      end
    end
  endtask

  task automatic test_lsb();
    data_ready_l = 1'b0;
    shift_bit_l(1'b1);
    shift_bit_l(1'b0);
    shift_bit_l(1'b0);
    exp_q_l.push_back(4'b0001);
    shift_bit_l(1'b0);
    n_checks++;
    if (parallel_out_l !== 4'b0001 || data_valid_l !== 1'b1) begin
      n_errors++;
      $display("FAIL lsb_word: got po=%b dv=%b, expected po=0001 dv=1", parallel_out_l, data_valid_l);
    end
    n_checks++;
    if (exp_q_l.size() == 0) begin
      n_errors++;
      $display("FAIL lsb_sb: got empty scoreboard, expected one word");
    end else begin
      exp_w = exp_q_l.pop_front();
      if (data_out_l !== exp_w) begin
        n_errors++;
        $display("FAIL lsb_data: got %b expected %b", data_out_l, exp_w);
      end
    end
    shift_bit_l(1'b1);
    shift_bit_l(1'b1);
    n_checks++;
    if (parallel_out_l !== 4'b1100 || bit_count_l !== 2'd2) begin
      n_errors++;
      $display("FAIL lsb_partial: got po=%b bc=%0d, expected po=1100 bc=2", parallel_out_l, bit_count_l);
    end
    clear_l = 1'b1;
    step();
    clear_l = 1'b0;
    n_checks++;
    if ({parallel_out_l, bit_count_l, data_out_l, data_valid_l, overrun_l} !== {4'b1111, 2'd0, 4'b0001, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL lsb_clear: got po=%b bc=%0d do=%b dv=%b ov=%b, expected po=1111 bc=0 do=0001 dv=0 ov=0",
               parallel_out_l, bit_count_l, data_out_l, data_valid_l, overrun_l);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_ready = 1'b0;
    shift_bit(1'b1);
    shift_bit(1'b0);
    shift_bit(1'b0);
    exp_q.push_back(4'b1001);
    shift_bit(1'b1);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL b2b_sb1: got empty scoreboard, expected one word");
    end else begin
      exp_w = exp_q.pop_front();
      if (data_out !== exp_w || data_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_first: got do=%b dv=%b, expected do=%b dv=1", data_out, data_valid, exp_w);
      end
    end
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b1);
    data_ready = 1'b1;
    exp_q.push_back(4'b0110);
    shift_bit(1'b0);
    data_ready = 1'b0;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL b2b_sb2: got empty scoreboard, expected one word");
    end else begin
      exp_w = exp_q.pop_front();
      if (data_out !== exp_w || data_valid !== 1'b1 || overrun !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_second: got do=%b dv=%b ov=%b, expected do=%b dv=1 ov=0",
                 data_out, data_valid, overrun, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overrun();
    test_discontiguous();
    test_lsb();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0 || exp_q_l.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d/%0d words left, expected 0/0", exp_q.size(), exp_q_l.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flex_stp_sr_frame.md
Name: flex_stp_sr_frame

Overview:
- Parametrised serial-to-parallel shift register with selectable shift direction, configurable width and idle fill value.
- Counts shifted bits and captures each completed NUM_BITS word into a holding register.
- Presents the captured word on a valid/ready handshake, with sticky overrun detection.
- Sits between a serial receive front end (bit-timing logic supplying shift_enable) and word-level consumer logic.

Parameters:
- NUM_BITS, 4, shift register and word width; legal range 2..32.
- SHIFT_MSB, 1, 1 = shift toward MSB (new bit enters bit 0); 0 = shift toward LSB (new bit enters bit NUM_BITS-1).
- INACTIVE_VALUE, 1'b1, fill value of every shift register bit after reset or clear.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous abort of the current word and flags.
- shift_enable  in  1  shift serial_in into the register this edge.
- serial_in  in  1  serial data bit.
- parallel_out  out  NUM_BITS  live shift register contents.
- bit_count  out  $clog2(NUM_BITS)  bits shifted into the current partial word.
- data_out  out  NUM_BITS  captured word; stable while data_valid=1.
- data_valid  out  1  captured word available.
- data_ready  in  1  consumer accepts data_out on an edge where data_valid=1.
- overrun  out  1  sticky: a word completed while the previous one was still unaccepted.

Behaviour:
- Priority per edge: rst > clear > shift/handshake.
- rst=1 at an edge: parallel_out={NUM_BITS{INACTIVE_VALUE}}, bit_count=0, data_out=0, data_valid=0, overrun=0.
  - rst held: values hold across edges.
  - rst has no effect between edges.
- clear=1 (rst=0): same values as rst, except data_out holds its value. shift_enable is ignored that edge.
- Shift when shift_enable=1:
  - SHIFT_MSB=1: sr <= {sr[NUM_BITS-2:0], serial_in}.
  - SHIFT_MSB=0: sr <= {serial_in, sr[NUM_BITS-1:1]}.
- No shift when shift_enable=0: sr and bit_count hold, for any number of cycles.
- bit_count increments on each shift and wraps NUM_BITS-1 -> 0.
- Completion: shift_enable=1 with bit_count=NUM_BITS-1. The post-shift sr value (including this bit) is the completed word.
- Capture on completion:
  - If data_valid=0, or data_valid=1 and data_ready=1 this edge: data_out <= completed word; data_valid=1 after the edge.
  - Latency: data_valid rises on the same edge that shifts in the last bit.
- Handshake:
  - data_valid=1 and data_ready=1 with no completion: data_valid <= 0 and data_out holds.
  - data_ready is ignored while data_valid=0.
  - Acceptance and completion on the same edge: the new word is loaded, data_valid stays 1, overrun is unchanged.
- Overrun:
  - Completion with data_valid=1 and data_ready=0: the new word is dropped; data_out and data_valid hold; overrun <= 1.
  - overrun stays set until rst or clear.
- Wrap: after completion, shifting continues seamlessly into the next word. sr is not refilled with INACTIVE_VALUE.
- Unknown or X serial_in is shifted in as-is; no filtering.

Test Plan:
- Power-on reset: assert rst 2 edges, check between edges. Expect parallel_out=4'b1111, bit_count=0, data_valid=0, overrun=0. Hold rst across an edge with shift_enable=1 and serial_in=0: values unchanged.
- Contiguous stream 1,1,0,1, SHIFT_MSB=1, data_ready=0: after the 4th edge, parallel_out=4'b1101, data_out=4'b1101, data_valid=1, bit_count=0.
- Continue with stream 0,0,1,0 and data_ready=0: parallel_out=4'b0010, data_out stays 4'b1101, overrun=1. Then data_ready=1 for one edge: data_valid=0. overrun stays 1 until clear.
- Discontiguous 0,0,0,0 with one idle cycle between bits, starting from reset: after each bit, parallel_out steps 1110, 1100, 1000, 0000. Each value holds through the idle cycle. data_valid rises only after the 4th bit.
- SHIFT_MSB=0 instance, stream 1,0,0,0: parallel_out=4'b0001, data_out=4'b0001. Clear after 2 bits of the next word: bit_count=0, parallel_out=4'b1111, data_valid=0, data_out stays 4'b0001.
- Simultaneous event: data_valid=1 holding 4'b1001; 4th bit of 4'b0110 arrives on the same edge as data_ready=1. Expect data_out=4'b0110, data_valid=1, overrun=0.
